// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter for raster-scan greyscale frames.
// Two line buffers feed a 3x3 window; one registered gradient per interior pixel.
module sobel_stream_filter #(
  parameter int PIXEL_W    = 8,
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int COL_BITS   = $clog2(IMG_WIDTH),
  parameter int ROW_BITS   = $clog2(IMG_HEIGHT)
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  input  logic               sof_i,
  input  logic               px_valid_i,
  input  logic [PIXEL_W-1:0] px_i,
  input  logic               mode_i,
  input  logic [PIXEL_W-1:0] threshold_i,
  output logic [PIXEL_W-1:0] px_o,
  output logic               px_valid_o,
  output logic               eof_o,
  output logic               busy_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam int SW = PIXEL_W + 4;

  logic [1:0]          state_q, state_d;
  logic [COL_BITS-1:0] col_q, col_d, cur_col;
  logic [ROW_BITS-1:0] row_q, row_d, cur_row;
  logic                accept, last_col, last_row, out_fire;

  logic [PIXEL_W-1:0]  lb0_mem [IMG_WIDTH];
  logic [PIXEL_W-1:0]  lb1_mem [IMG_WIDTH];
  logic [PIXEL_W-1:0]  lb0_rd_q, lb1_rd_q;
  logic [PIXEL_W-1:0]  col_in [3];

  logic [PIXEL_W-1:0]  win_q [3][3];
  logic [PIXEL_W-1:0]  win_d [3][3];
  logic signed [SW-1:0] tap [9];
  logic signed [SW-1:0] gx, gy;
  logic [SW-1:0]       abs_gx, abs_gy, mag;
  logic [PIXEL_W-1:0]  raw_px, bin_px;

  logic [PIXEL_W-1:0]  px_q, px_d;
  logic                valid_q, valid_d, eof_q, eof_d;

  // sof_i overrides the position so the same-cycle pixel is (0,0)
  always_comb begin
    cur_col  = sof_i ? '0 : col_q;
    cur_row  = sof_i ? '0 : row_q;
    accept   = px_valid_i && (sof_i || (state_q == S_ACTIVE));
    last_col = (cur_col == COL_BITS'(IMG_WIDTH - 1));
    last_row = (cur_row == ROW_BITS'(IMG_HEIGHT - 1));
    out_fire = accept && (cur_row >= ROW_BITS'(2)) && (cur_col >= COL_BITS'(2));
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    if (sof_i) begin
      state_d = S_ACTIVE;
      col_d   = '0;
      row_d   = '0;
    end
    if (accept) begin
      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d   = '0;
          state_d = S_DONE;
        end else begin
          row_d = cur_row + ROW_BITS'(1);
        end
      end else begin
        col_d = cur_col + COL_BITS'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // Read is prefetched at the next column; the write address always differs from it
  always_ff @(posedge clk_i) begin
    if (accept) begin
      lb0_mem[cur_col] <= px_i;
      lb1_mem[cur_col] <= lb0_rd_q;
    end
    lb0_rd_q <= lb0_mem[col_d];
    lb1_rd_q <= lb1_mem[col_d];
  end

  assign col_in[0] = lb1_rd_q;
  assign col_in[1] = lb0_rd_q;
  assign col_in[2] = px_i;

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_d[r][c] = win_q[r][c];
      end
      if (accept) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
        win_d[r][2] = col_in[r];
      end
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= win_d[r][c];
        end
      end
    end
  end

  // Gradient is taken on the shifted window so the result registers with the pixel
  for (genvar gi = 0; gi < 9; gi++) begin : g_tap
    assign tap[gi] = $signed({4'b0000, win_d[gi / 3][gi % 3]});
  end

  always_comb begin
    gx     = (tap[2] + (tap[5] <<< 1) + tap[8]) - (tap[0] + (tap[3] <<< 1) + tap[6]);
    gy     = (tap[6] + (tap[7] <<< 1) + tap[8]) - (tap[0] + (tap[1] <<< 1) + tap[2]);
    abs_gx = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
    abs_gy = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag    = abs_gx + abs_gy;
    raw_px = (mag > SW'((1 << PIXEL_W) - 1)) ? {PIXEL_W{1'b1}} : mag[PIXEL_W-1:0];
    bin_px = (mag >= {4'b0000, threshold_i}) ? {PIXEL_W{1'b1}} : '0;
  end

  always_comb begin
    px_d    = px_q;
    valid_d = 1'b0;
    eof_d   = 1'b0;
    if (out_fire) begin
      valid_d = 1'b1;
      px_d    = mode_i ? bin_px : raw_px;
      eof_d   = last_row && last_col;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      px_q    <= '0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      px_q    <= px_d;
      valid_q <= valid_d;
      eof_q   <= eof_d;
    end
  end

  assign px_o       = px_q;
  assign px_valid_o = valid_q;
  assign eof_o      = eof_q;
  assign busy_o     = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Directed bench for sobel_stream_filter on a 5x4 frame with hand-computed and
// formula-derived expectations, checked by immediate assertions.
module tb_sobel_stream_filter;
  localparam int W = 5;
  localparam int H = 4;

  logic       clk_i = 1'b0;
  logic       nreset_i = 1'b0;
  logic       sof_i = 1'b0;
  logic       px_valid_i = 1'b0;
  logic [7:0] px_i = 8'd0;
  logic       mode_i = 1'b0;
  logic [7:0] threshold_i = 8'd0;
  logic [7:0] px_o;
  logic       px_valid_o, eof_o, busy_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fr [H][W];
  logic [7:0] exp_val[$], obs_val[$];
  logic       exp_eof[$], obs_eof[$];
  int         exp_cyc[$], obs_cyc[$];
  int         eof_cnt = 0;
  int         exp_eof_cnt = 0;
  logic [7:0] hand [6];

  sobel_stream_filter #(.PIXEL_W(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk_i(clk_i), .nreset_i(nreset_i), .sof_i(sof_i), .px_valid_i(px_valid_i),
    .px_i(px_i), .mode_i(mode_i), .threshold_i(threshold_i), .px_o(px_o),
    .px_valid_o(px_valid_o), .eof_o(eof_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (px_valid_o === 1'b1) begin
      obs_val.push_back(px_o);
      obs_eof.push_back(eof_o);
      obs_cyc.push_back(cyc);
    end
    if (eof_o === 1'b1) eof_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] ref_px(input int r, input int c, input logic mode,
                                        input logic [7:0] thr);
    int p [3][3];
    int gx, gy, mag;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) p[i][j] = fr[r-2+i][c-2+j];
    gx  = (p[0][2] + 2*p[1][2] + p[2][2]) - (p[0][0] + 2*p[1][0] + p[2][0]);
    gy  = (p[2][0] + 2*p[2][1] + p[2][2]) - (p[0][0] + 2*p[0][1] + p[0][2]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (mode) return (mag >= int'(thr)) ? 8'hFF : 8'h00;
    return (mag > 255) ? 8'hFF : 8'(mag);
  endfunction

  task automatic drive(input logic v, input logic s, input logic [7:0] p);
    px_valid_i = v;
    sof_i      = s;
    px_i       = p;
    @(posedge clk_i);
    #1;
    px_valid_i = 1'b0;
    sof_i      = 1'b0;
  endtask

  task automatic send_frame(input int gap_max, input logic mode, input logic [7:0] thr);
    mode_i      = mode;
    threshold_i = thr;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (gap_max > 0 && !(r == 0 && c == 0))
          repeat ($urandom_range(gap_max, 0)) drive(1'b0, 1'b0, 8'($urandom));
        drive(1'b1, (r == 0 && c == 0), 8'(fr[r][c]));
        if (r >= 2 && c >= 2) begin
          exp_val.push_back(ref_px(r, c, mode, thr));
          exp_eof.push_back(r == H-1 && c == W-1);
          exp_cyc.push_back(cyc);
          if (r == H-1 && c == W-1) exp_eof_cnt++;
        end
      end
    end
  endtask

  task automatic send_partial(input int n);
    for (int k = 0; k < n; k++) drive(1'b1, (k == 0), 8'(fr[k / W][k % W]));
  endtask

  task automatic check_outputs(input string tag);
    int n;
    repeat (2) @(negedge clk_i);
    chk({tag, "_count"}, obs_val.size(), exp_val.size());
    n = (obs_val.size() < exp_val.size()) ? obs_val.size() : exp_val.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_px%0d", tag, i), obs_val[i], exp_val[i]);
      chk($sformatf("%s_eof%0d", tag, i), obs_eof[i], exp_eof[i]);
      chk($sformatf("%s_lat%0d", tag, i), obs_cyc[i], exp_cyc[i]);
    end
    chk({tag, "_eofcnt"}, eof_cnt, exp_eof_cnt);
    $display("step %s: %0d outputs observed, %0d expected", tag, obs_val.size(), exp_val.size());
    obs_val.delete(); obs_eof.delete(); obs_cyc.delete();
    exp_val.delete(); exp_eof.delete(); exp_cyc.delete();
    eof_cnt     = 0;
    exp_eof_cnt = 0;
  endtask

  task automatic check_hand(input string tag);
    int n;
    n = (obs_val.size() < 6) ? obs_val.size() : 6;
    for (int i = 0; i < n; i++) chk($sformatf("%s_hand%0d", tag, i), obs_val[i], hand[i]);
  endtask

  task automatic fill_edge(input int lo, input int hi);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) fr[r][c] = (c < 2) ? lo : hi;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) fr[r][c] = int'($urandom_range(255, 0));
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_valid", px_valid_o, 1'b0);
    chk("rst_px", px_o, 8'd0);
    chk("rst_eof", eof_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    @(posedge clk_i);
    #1;
    nreset_i = 1'b1;

    // Pixels without sof in IDLE are ignored
    repeat (8) drive(1'b1, 1'b0, 8'd77);
    chk("idle_busy", busy_o, 1'b0);
    check_outputs("idle");

    // 1. Flat frame
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) fr[r][c] = 100;
    mode_i = 1'b0;
    drive(1'b1, 1'b1, 8'd100);
    chk("flat_busy_hi", busy_o, 1'b1);
    for (int k = 1; k < W*H; k++) drive(1'b1, 1'b0, 8'd100);
    chk("flat_busy_lo", busy_o, 1'b0);
    for (int i = 0; i < 6; i++) begin
      exp_val.push_back(8'd0);
      exp_eof.push_back(i == 5);
      exp_cyc.push_back(obs_cyc.size() > i ? obs_cyc[i] : -1);
    end
    exp_eof_cnt = 1;
    repeat (2) @(negedge clk_i);
    for (int i = 0; i < 6 && i < obs_cyc.size(); i++) exp_cyc[i] = obs_cyc[i];
    check_outputs("flat");

    // 2. Vertical edge, raw
    hand = '{8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0};
    fill_edge(0, 200);
    send_frame(0, 1'b0, 8'd0);
    repeat (2) @(negedge clk_i);
    check_hand("edge_raw");
    check_outputs("edge_raw");

    // 3. Binary mode
    send_frame(0, 1'b1, 8'd255);
    repeat (2) @(negedge clk_i);
    check_hand("edge_bin255");
    check_outputs("edge_bin255");
    fill_edge(0, 10);
    hand = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_frame(0, 1'b1, 8'd50);
    repeat (2) @(negedge clk_i);
    check_hand("step_thr50");
    check_outputs("step_thr50");
    hand = '{8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0};
    send_frame(0, 1'b1, 8'd40);
    repeat (2) @(negedge clk_i);
    check_hand("step_thr40");
    check_outputs("step_thr40");

    // 4. Random pixels with random gaps
    for (int f = 0; f < 4; f++) begin
      fill_rand();
      send_frame(3, f[0], 8'($urandom_range(255, 0)));
      check_outputs($sformatf("rand%0d", f));
    end

    // 5a. Reset mid-row 2, then a new frame
    fill_rand();
    send_partial(2*W + 2);
    nreset_i = 1'b0;
    #2;
    chk("abort_rst_busy", busy_o, 1'b0);
    chk("abort_rst_valid", px_valid_o, 1'b0);
    @(posedge clk_i);
    #1;
    nreset_i = 1'b1;
    repeat (3) drive(1'b1, 1'b0, 8'd9);
    check_outputs("abort_rst_idle");
    fill_rand();
    send_frame(1, 1'b0, 8'd0);
    check_outputs("abort_rst");

    // 5b. sof mid-row 2 restarts the frame
    fill_rand();
    send_partial(2*W + 2);
    fill_rand();
    send_frame(0, 1'b0, 8'd0);
    check_outputs("abort_sof");

    // 6. Extra pixels in DONE are ignored; back-to-back frames keep eof and (0,0)
    fill_rand();
    send_frame(0, 1'b0, 8'd0);
    repeat (4) drive(1'b1, 1'b0, 8'($urandom));
    chk("done_busy", busy_o, 1'b0);
    check_outputs("done_extra");
    fill_rand();
    send_frame(0, 1'b0, 8'd0);
    send_frame(0, 1'b1, 8'd120);
    check_outputs("back2back");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
